// File: rtl/alu_op_sequencer_pkg.sv
// Opcode map, FSM state encodings and opcode-class helpers shared by the ALU
// instruction sequencer and its decoders.
package alu_op_sequencer_pkg;

  localparam int OPC_W     = 5;
  localparam int REG_IDX_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD = 5'd3;
  localparam logic [OPC_W-1:0] OP_SUB = 5'd4;
  localparam logic [OPC_W-1:0] OP_AND = 5'd5;
  localparam logic [OPC_W-1:0] OP_OR  = 5'd6;
  localparam logic [OPC_W-1:0] OP_MUL = 5'd15;
  localparam logic [OPC_W-1:0] OP_DIV = 5'd16;
  localparam logic [OPC_W-1:0] OP_NEG = 5'd17;
  localparam logic [OPC_W-1:0] OP_NOT = 5'd18;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T3   = 3'd1;
  localparam logic [2:0] ST_T4   = 3'd2;
  localparam logic [2:0] ST_T5   = 3'd3;
  localparam logic [2:0] ST_T6   = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  function automatic logic op_is_binary(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic op_is_muldiv(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_unary(input logic [OPC_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
    return op_is_binary(op) || op_is_muldiv(op) || op_is_unary(op);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_onehot_dec.sv
// Register index to one-hot select decoder; purely combinational, zero latency.
// No handshake: output is all-zero whenever en is low.
module alu_op_sequencer_onehot_dec #(
  parameter int IDX_W = 4,
  parameter int N     = 16
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  assign onehot = en ? (N'(1) << idx) : '0;

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle bus sequencer for reg-reg ALU ops: 4 cycles binary, 3 unary, 4+MULDIV_WAIT mul/div, 2 illegal.
// Accepts one request at a time; start is only sampled in IDLE and is dropped while busy.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int NREGS       = 16,
  parameter int RSEL_W      = REG_IDX_W,
  parameter int OP_W        = OPC_W,
  parameter int MULDIV_WAIT = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic [RSEL_W-1:0] ra,
  input  logic [RSEL_W-1:0] rb,
  input  logic [RSEL_W-1:0] rc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NREGS-1:0]  reg_out,
  output logic [NREGS-1:0]  reg_in,
  output logic              y_in,
  output logic              z_in,
  output logic [OP_W-1:0]   alu_op,
  output logic              zlo_out,
  output logic              zhi_out,
  output logic              lo_in,
  output logic              hi_in
);

  localparam int CNT_W = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MULDIV_WAIT - 1);

  logic [2:0]        state;
  logic [OP_W-1:0]   op_q;
  logic [RSEL_W-1:0] ra_q;
  logic [RSEL_W-1:0] rb_q;
  logic [RSEL_W-1:0] rc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              q_muldiv;
  logic              q_unary;
  logic              q_illegal;

  assign q_muldiv  = op_is_muldiv(op_q);
  assign q_unary   = op_is_unary(op_q);
  assign q_illegal = !op_is_legal(op_q);

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= ST_IDLE;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= opcode;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
            if (!op_is_legal(opcode)) begin
              state <= ST_ERR;
            end else if (op_is_unary(opcode)) begin
              state <= ST_T4;
              cnt_q <= '0;
            end else begin
              state <= ST_T3;
            end
          end
        end
        ST_T3: begin
          state <= ST_T4;
          cnt_q <= q_muldiv ? WAIT_LOAD : '0;
        end
        ST_T4: begin
          // Mul/div hold T4 with all strobes frozen until the wait count drains.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state <= ST_T5;
          end
        end
        ST_T5:   state <= q_muldiv ? ST_T6 : ST_DONE;
        ST_T6:   state <= ST_DONE;
        ST_ERR:  state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic              rout_en;
  logic [RSEL_W-1:0] rout_idx;
  logic              rin_en;

  always_comb begin
    rout_en  = (state == ST_T3) || (state == ST_T4);
    rout_idx = ((state == ST_T4) && !q_unary) ? rc_q : rb_q;
    rin_en   = (state == ST_T5) && !q_muldiv;
  end

  alu_op_sequencer_onehot_dec #(
    .IDX_W (RSEL_W),
    .N     (NREGS)
  ) u_dec_out (
    .en     (rout_en),
    .idx    (rout_idx),
    .onehot (reg_out)
  );

  alu_op_sequencer_onehot_dec #(
    .IDX_W (RSEL_W),
    .N     (NREGS)
  ) u_dec_in (
    .en     (rin_en),
    .idx    (ra_q),
    .onehot (reg_in)
  );

  always_comb begin
    busy    = (state != ST_IDLE);
    done    = (state == ST_DONE);
    err     = (state == ST_DONE) && q_illegal;
    y_in    = (state == ST_T3);
    z_in    = (state == ST_T4);
    alu_op  = (state == ST_T4) ? op_q : '0;
    zlo_out = (state == ST_T5);
    lo_in   = (state == ST_T5) && q_muldiv;
    zhi_out = (state == ST_T6);
    hi_in   = (state == ST_T6);
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomized checks of alu_op_sequencer against a per-cycle expected-output queue.
// The queue is built from the instruction timing rules; literal checks pin the directed cases.
module tb_alu_op_sequencer;

  localparam int WAIT = 4;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] reg_out;
    logic [15:0] reg_in;
    logic        y_in;
    logic        z_in;
    logic [4:0]  alu_op;
    logic        zlo_out;
    logic        zhi_out;
    logic        lo_in;
    logic        hi_in;
  } out_t;

  logic        clock;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        busy, done, err;
  logic [15:0] reg_out, reg_in;
  logic        y_in, z_in;
  logic [4:0]  alu_op;
  logic        zlo_out, zhi_out, lo_in, hi_in;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  out_t exp_q[$];
  out_t cur;

  alu_op_sequencer #(
    .NREGS       (16),
    .RSEL_W      (4),
    .OP_W        (5),
    .MULDIV_WAIT (WAIT)
  ) dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .opcode  (opcode),
    .ra      (ra),
    .rb      (rb),
    .rc      (rc),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .reg_out (reg_out),
    .reg_in  (reg_in),
    .y_in    (y_in),
    .z_in    (z_in),
    .alu_op  (alu_op),
    .zlo_out (zlo_out),
    .zhi_out (zhi_out),
    .lo_in   (lo_in),
    .hi_in   (hi_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic is_legal(input logic [4:0] op);
    return op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd15, 5'd16, 5'd17, 5'd18};
  endfunction

  // Expected outputs for every cycle of one instruction, from accept to done.
  task automatic push_seq(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c);
    out_t v;
    bit   md;
    md = (op == 5'd15) || (op == 5'd16);
    if (!is_legal(op)) begin
      v = '0; v.busy = 1'b1;
      exp_q.push_back(v);
      v.done = 1'b1; v.err = 1'b1;
      exp_q.push_back(v);
    end else if (op == 5'd17 || op == 5'd18) begin
      v = '0; v.busy = 1'b1; v.reg_out = 16'(1) << b; v.alu_op = op; v.z_in = 1'b1;
      exp_q.push_back(v);
      v = '0; v.busy = 1'b1; v.zlo_out = 1'b1; v.reg_in = 16'(1) << a;
      exp_q.push_back(v);
      v = '0; v.busy = 1'b1; v.done = 1'b1;
      exp_q.push_back(v);
    end else begin
      v = '0; v.busy = 1'b1; v.reg_out = 16'(1) << b; v.y_in = 1'b1;
      exp_q.push_back(v);
      v = '0; v.busy = 1'b1; v.reg_out = 16'(1) << c; v.alu_op = op; v.z_in = 1'b1;
      for (int i = 0; i < (md ? WAIT : 1); i++) exp_q.push_back(v);
      if (md) begin
        v = '0; v.busy = 1'b1; v.zlo_out = 1'b1; v.lo_in = 1'b1;
        exp_q.push_back(v);
        v = '0; v.busy = 1'b1; v.zhi_out = 1'b1; v.hi_in = 1'b1;
        exp_q.push_back(v);
      end else begin
        v = '0; v.busy = 1'b1; v.zlo_out = 1'b1; v.reg_in = 16'(1) << a;
        exp_q.push_back(v);
      end
      v = '0; v.busy = 1'b1; v.done = 1'b1;
      exp_q.push_back(v);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare all outputs 1 time unit later.
  task automatic step(input logic st, input logic [4:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] c, input logic clr);
    out_t act;
    start = st; opcode = op; ra = a; rb = b; rc = c; clear = clr;
    @(posedge clock);
    cyc++;
    if (clr) begin
      exp_q.delete();
      cur = '0;
    end else begin
      if (!cur.busy && st) push_seq(op, a, b, c);
      cur = (exp_q.size() != 0) ? exp_q.pop_front() : out_t'('0);
    end
    #1;
    act = '{busy, done, err, reg_out, reg_in, y_in, z_in, alu_op, zlo_out, zhi_out, lo_in, hi_in};
    checks++;
    if (act !== cur) begin
      failures++;
      $display("FAIL cycle_%0d outputs got=%h want=%h", cyc, act, cur);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, a, e);
    end
  endtask

  initial begin
    cur = '0;
    start = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0; clear = 1'b1;
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_strobes", {reg_out, reg_in}, 32'd0);
    chk("reset_misc", 32'({done, err, y_in, z_in, alu_op, zlo_out, zhi_out, lo_in, hi_in}), 32'd0);
    idle(1);

    // OR r3 = r1 | r2
    step(1'b1, 5'd6, 4'd3, 4'd1, 4'd2, 1'b0);
    chk("or_c1_reg_out", 32'(reg_out), 32'h0002);
    chk("or_c1_y_in", 32'(y_in), 32'd1);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("or_c2_reg_out", 32'(reg_out), 32'h0004);
    chk("or_c2_alu", 32'({z_in, alu_op}), 32'h26);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("or_c3_reg_in", 32'(reg_in), 32'h0008);
    chk("or_c3_zlo", 32'(zlo_out), 32'd1);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("or_c4_done_err", 32'({done, err}), 32'h2);
    idle(1);

    // MUL rb=5 rc=6: Z held for WAIT cycles, then LO then HI
    step(1'b1, 5'd15, 4'd0, 4'd5, 4'd6, 1'b0);
    chk("mul_c1_reg_out", 32'(reg_out), 32'h0020);
    for (int i = 0; i < WAIT; i++) begin
      step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
      chk("mul_t4_hold", {reg_out, 11'd0, z_in, alu_op}, {16'h0040, 11'd0, 1'b1, 5'd15});
    end
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("mul_c6_lo", 32'({zlo_out, lo_in, reg_in}), {14'd0, 2'b11, 16'h0});
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("mul_c7_hi", 32'({zhi_out, hi_in}), 32'h3);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("mul_c8_done", 32'(done), 32'd1);
    idle(1);

    // NOT r7 = ~r7
    step(1'b1, 5'd18, 4'd7, 4'd7, 4'd0, 1'b0);
    chk("not_c1", {reg_out, 11'd0, alu_op}, {16'h0080, 11'd0, 5'd18});
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("not_c2_reg_in", 32'(reg_in), 32'h0080);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("not_c3_done", 32'(done), 32'd1);
    idle(1);

    // Illegal opcode
    step(1'b1, 5'd31, 4'd9, 4'd1, 4'd2, 1'b0);
    chk("ill_c1_nostrobe", {reg_out, reg_in}, 32'd0);
    chk("ill_c1_busy", 32'({busy, y_in, z_in}), 32'h4);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("ill_c2_done_err", 32'({done, err, reg_in}), {14'd0, 2'b11, 16'h0});
    idle(1);

    // Clear while in T4 of an ADD
    step(1'b1, 5'd3, 4'd4, 4'd1, 4'd2, 1'b0);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("clr_in_t4", 32'(z_in), 32'd1);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_outputs", {reg_out, reg_in}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
      chk("clr_no_write", 32'({reg_in, done}), 32'd0);
    end

    // start held during c1 and c2 of an OR is ignored
    step(1'b1, 5'd6, 4'd3, 4'd1, 4'd2, 1'b0);
    step(1'b1, 5'd4, 4'd9, 4'd9, 4'd9, 1'b0);
    step(1'b1, 5'd4, 4'd9, 4'd9, 4'd9, 1'b0);
    chk("busy_start_c3_reg_in", 32'(reg_in), 32'h0008);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("busy_start_c4_done", 32'(done), 32'd1);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("busy_start_single", 32'({busy, done}), 32'd0);

    // Randomized traffic, including start during DONE and occasional clear
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op;
      logic       cl;
      logic       st;
      logic [2:0] pick;
      pick = 3'($urandom_range(0, 7));
      case (pick)
        3'd0: op = 5'd3;  3'd1: op = 5'd4;  3'd2: op = 5'd5;  3'd3: op = 5'd6;
        3'd4: op = 5'd15; 3'd5: op = 5'd16; 3'd6: op = 5'd17; default: op = 5'd18;
      endcase
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
      st = ($urandom_range(0, 2) == 0);
      cl = ($urandom_range(0, 59) == 0);
      step(st, op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), cl);
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
